// File: rtl/axi_wr_arbiter_pkg.sv
// Shared definitions for the two-requester AXI4 write-channel arbiter.
package axi_wr_arbiter_pkg;

  localparam int unsigned AXI_LEN_W  = 8;
  localparam int unsigned AXI_RESP_W = 2;

  localparam logic REQ_DMA    = 1'b0;
  localparam logic REQ_CRYPTO = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AW   = 2'd1,
    ST_W    = 2'd2
  } arb_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with full/empty/count; a pop frees a slot for a same-cycle push.
module sync_fifo #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != (PTR_W+1)'(DEPTH)) || do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/axi_wr_arbiter.sv
// Burst-granular round-robin arbiter sharing one AXI4 write master between DMA and crypto,
// regenerating WLAST from AWLEN and routing B responses through an in-order ID FIFO.
module axi_wr_arbiter
  import axi_wr_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned B_FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   s0_axi_awaddr,
  input  logic [AXI_LEN_W-1:0]    s0_axi_awlen,
  input  logic                    s0_axi_awvalid,
  output logic                    s0_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s0_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s0_axi_wstrb,
  input  logic                    s0_axi_wlast,
  input  logic                    s0_axi_wvalid,
  output logic                    s0_axi_wready,
  output logic [AXI_RESP_W-1:0]   s0_axi_bresp,
  output logic                    s0_axi_bvalid,
  input  logic                    s0_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s1_axi_awaddr,
  input  logic [AXI_LEN_W-1:0]    s1_axi_awlen,
  input  logic                    s1_axi_awvalid,
  output logic                    s1_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s1_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s1_axi_wstrb,
  input  logic                    s1_axi_wlast,
  input  logic                    s1_axi_wvalid,
  output logic                    s1_axi_wready,
  output logic [AXI_RESP_W-1:0]   s1_axi_bresp,
  output logic                    s1_axi_bvalid,
  input  logic                    s1_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [AXI_LEN_W-1:0]    m_axi_awlen,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [AXI_RESP_W-1:0]   m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic                    o_proto_err,
  output logic                    o_busy
);

  localparam int unsigned CNT_W = $clog2(B_FIFO_DEPTH) + 1;

  arb_state_e           state_q, state_d;
  logic                 grant_q, grant_d;
  logic                 last_q, last_d;
  logic                 proto_err_q, proto_err_d;
  logic [AXI_LEN_W-1:0] len_q, len_d;
  logic [AXI_LEN_W-1:0] beat_cnt_q, beat_cnt_d;
  logic                 sel_wlast;
  logic                 fifo_push, fifo_pop, fifo_full, fifo_empty, fifo_head;
  logic [CNT_W-1:0]     fifo_count;

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    last_d         = last_q;
    proto_err_d    = proto_err_q;
    len_d          = len_q;
    beat_cnt_d     = beat_cnt_q;
    fifo_push      = 1'b0;
    sel_wlast      = 1'b0;
    m_axi_awvalid  = 1'b0;
    m_axi_awaddr   = '0;
    m_axi_awlen    = '0;
    s0_axi_awready = 1'b0;
    s1_axi_awready = 1'b0;
    m_axi_wvalid   = 1'b0;
    m_axi_wdata    = '0;
    m_axi_wstrb    = '0;
    m_axi_wlast    = 1'b0;
    s0_axi_wready  = 1'b0;
    s1_axi_wready  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A B pop in this cycle frees the slot this grant will consume
        if ((s0_axi_awvalid || s1_axi_awvalid) && (!fifo_full || fifo_pop)) begin
          if (s0_axi_awvalid && s1_axi_awvalid) begin
            grant_d = ~last_q;
          end else begin
            grant_d = s1_axi_awvalid ? REQ_CRYPTO : REQ_DMA;
          end
          state_d = ST_AW;
        end
      end
      ST_AW: begin
        m_axi_awvalid = 1'b1;
        if (grant_q == REQ_CRYPTO) begin
          m_axi_awaddr   = s1_axi_awaddr;
          m_axi_awlen    = s1_axi_awlen;
          s1_axi_awready = m_axi_awready;
        end else begin
          m_axi_awaddr   = s0_axi_awaddr;
          m_axi_awlen    = s0_axi_awlen;
          s0_axi_awready = m_axi_awready;
        end
        if (m_axi_awready) begin
          len_d      = m_axi_awlen;
          beat_cnt_d = '0;
          fifo_push  = 1'b1;
          state_d    = ST_W;
        end
      end
      ST_W: begin
        m_axi_wlast = (beat_cnt_q == len_q);
        if (grant_q == REQ_CRYPTO) begin
          m_axi_wvalid  = s1_axi_wvalid;
          m_axi_wdata   = s1_axi_wdata;
          m_axi_wstrb   = s1_axi_wstrb;
          sel_wlast     = s1_axi_wlast;
          s1_axi_wready = m_axi_wready;
        end else begin
          m_axi_wvalid  = s0_axi_wvalid;
          m_axi_wdata   = s0_axi_wdata;
          m_axi_wstrb   = s0_axi_wstrb;
          sel_wlast     = s0_axi_wlast;
          s0_axi_wready = m_axi_wready;
        end
        if (m_axi_wvalid && m_axi_wready) begin
          beat_cnt_d = beat_cnt_q + AXI_LEN_W'(1);
          if (sel_wlast != m_axi_wlast) begin
            proto_err_d = 1'b1;
          end
          if (m_axi_wlast) begin
            last_d  = grant_q;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    s0_axi_bvalid = 1'b0;
    s1_axi_bvalid = 1'b0;
    s0_axi_bresp  = '0;
    s1_axi_bresp  = '0;
    m_axi_bready  = 1'b0;
    if (!fifo_empty) begin
      if (fifo_head == REQ_CRYPTO) begin
        s1_axi_bvalid = m_axi_bvalid;
        s1_axi_bresp  = m_axi_bresp;
        m_axi_bready  = s1_axi_bready;
      end else begin
        s0_axi_bvalid = m_axi_bvalid;
        s0_axi_bresp  = m_axi_bresp;
        m_axi_bready  = s0_axi_bready;
      end
    end
  end

  assign fifo_pop = m_axi_bvalid && m_axi_bready;

  sync_fifo #(
    .WIDTH (1),
    .DEPTH (B_FIFO_DEPTH)
  ) u_id_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (grant_q),
    .pop   (fifo_pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      grant_q     <= REQ_DMA;
      last_q      <= REQ_CRYPTO;
      proto_err_q <= 1'b0;
      len_q       <= '0;
      beat_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      proto_err_q <= proto_err_d;
      len_q       <= len_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

  assign o_proto_err = proto_err_q;
  assign o_busy      = (state_q != ST_IDLE) || (fifo_count != '0);

endmodule

// File: doc/axi_wr_arbiter.md
# axi_wr_arbiter

Two-requester AXI4 write-channel arbiter that shares the single DDR write master port between the DMA master engine (requester 0) and the crypto result writer (requester 1). It grants at burst granularity with round-robin fairness and forwards one complete burst (AW then W) at a time. It regenerates WLAST from AWLEN, and routes write responses back to the originating requester through an in-order ID FIFO. It sits in the DMA subsystem between the requesters and the top-level m_axi write port; static AXI attributes (awsize, awburst, awcache, awprot) stay driven at the top level.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8
- B_FIFO_DEPTH, 4, outstanding-burst limit (power of 2, ≥2)

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- s{0,1}_axi_awaddr  in  ADDR_WIDTH  requester burst address
- s{0,1}_axi_awlen  in  8  beats−1
- s{0,1}_axi_awvalid / s{0,1}_axi_awready  in / out  1  AW handshake
- s{0,1}_axi_wdata  in  DATA_WIDTH  write data
- s{0,1}_axi_wstrb  in  DATA_WIDTH/8  byte strobes
- s{0,1}_axi_wlast  in  1  requester last-beat flag (checked only)
- s{0,1}_axi_wvalid / s{0,1}_axi_wready  in / out  1  W handshake
- s{0,1}_axi_bresp  out  2  routed response
- s{0,1}_axi_bvalid / s{0,1}_axi_bready  out / in  1  B handshake
- m_axi_awaddr, m_axi_awlen, m_axi_awvalid (out); m_axi_awready (in)  master AW channel
- m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid (out); m_axi_wready (in)  master W channel
- m_axi_bresp, m_axi_bvalid (in); m_axi_bready (out)  master B channel
- o_proto_err  out  1  sticky: requester WLAST mismatched AWLEN
- o_busy  out  1  state ≠ IDLE or ID FIFO non-empty

## Operation
- FSM states: IDLE, AW, W.
- IDLE:
  - When ≥1 s_awvalid is high and the ID FIFO is not full, register the grant and go to AW.
  - If both requesters are valid, grant the one not granted last. The round-robin pointer resets to "last = 1", so requester 0 wins the first tie.
- AW:
  - m_axi_aw* = granted requester's AW fields; the granted requester's awready = m_axi_awready.
  - On handshake: latch awlen into len_q, clear beat_cnt, push the grant index into the ID FIFO, and go to W.
- W:
  - Pass wdata, wstrb and wvalid/wready combinationally between the granted requester and the master.
  - m_axi_wlast = (beat_cnt == len_q); beat_cnt increments on each handshake.
  - On the handshake with m_axi_wlast: update the round-robin pointer and go to IDLE.
  - If s_wlast ≠ m_axi_wlast on any handshake beat, set o_proto_err (clears only on rst). The burst still ends on the beat count.
- Non-granted requester: awready = wready = 0.
- B path:
  - The FIFO head selects the target requester; m_axi_bvalid/bresp are forwarded to it and its bready is returned as m_axi_bready.
  - Pop on the B handshake.
  - With the FIFO empty, m_axi_bready = 0 and both s_bvalid = 0.
- A simultaneous FIFO push (AW) and pop (B) in the same cycle is legal; the count is unchanged.

## Timing
- Reset:
  - State IDLE, FIFO empty, beat_cnt = 0, len_q = 0, o_proto_err = 0, o_busy = 0.
  - All valid/ready outputs and all data outputs are 0.
- Reset mid-burst aborts the burst silently; the outstanding B routing state is lost. Resets are system-wide only.
- Arbitration latency: s_awvalid seen in IDLE at cycle N → m_axi_awvalid at N+1.
- Zero-cycle combinational paths: awready, W channel and B channel.
- Back-to-back bursts: the cycle after the last W handshake is IDLE, so there is one bubble cycle per burst.
- Once raised, m_axi_awvalid holds with stable fields until m_axi_awready (requesters must hold AW stable per AXI).
- FIFO full: no new grant. AW stalls until a B pop frees an entry; pop and grant may occur in the same cycle.

## Structure
- Shared package: REQ_DMA = 0, REQ_CRYPTO = 1, the arbiter state enum, and AXI burst-field widths (AXI_LEN_W = 8, AXI_RESP_W = 2).
- Sub-module: sync_fifo (parameterised width/depth, full/empty/count). It holds the 1-bit requester IDs.

## Test plan
- Single burst: s0 awaddr 0x1000, awlen 3, 4 beats, m_axi_awready/wready always 1 → m_axi_awvalid rises 1 cycle after s0_awvalid; wlast on beat 4; bresp OKAY returned on s0 only.
- Contention: both request in the same cycle, repeated 4 bursts each → grant order 0,1,0,1,…; no W interleaving within a burst.
- Outstanding limit: m_axi_bvalid held 0, 5 bursts of awlen 0 issued → exactly 4 AW handshakes; the 5th AW occurs the cycle a B pops.
- Backpressure: random m_axi_wready (50%), awlen 15 → 16 beats transferred in order, data/strobe unchanged, exactly one wlast.
- Protocol error: s1 awlen 2 but wlast asserted on beat 2 → o_proto_err = 1 and stays 1; the master still sees 3 beats with wlast on the 3rd.
- Async reset asserted mid-W → all outputs 0 immediately; after release, a new s0 burst completes normally.
